// File: rtl/gpreg_wb_arbiter.sv
// gpreg_wb_arbiter: write-back arbiter for the 8-entry GP register file.
// Merges ALU and memory-load write-backs using round-robin arbitration and can
// sequence a clear of all eight registers.
// Ports:
//    clk, rst                      clock; synchronous active-low reset
//    alu_req/alu_sel/alu_data      ALU write-back request, target, data
//    alu_gnt                       one-cycle grant to ALU
//    mem_req/mem_sel/mem_data      load write-back request, target, data
//    mem_gnt                       one-cycle grant to MEM
//    clr_req                       request to zero all GP registers
//    clr_busy/clr_done             clear in progress / completion pulse
//    rf_sel_z/rf_mem_instr/rf_wdata  register-file write port (2'b11 write, 2'b00 nop)
// Optional build macro GPREG_WB_DBG_EN adds a strict-priority debug requester:
//    dbg_req/dbg_sel/dbg_data in, dbg_gnt out.
module gpreg_wb_arbiter #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_req,
   input  logic [2:0]  alu_sel,
   input  logic [31:0] alu_data,
   output logic        alu_gnt,
   input  logic        mem_req,
   input  logic [2:0]  mem_sel,
   input  logic [31:0] mem_data,
   output logic        mem_gnt,
`ifdef GPREG_WB_DBG_EN
   input  logic        dbg_req,
   input  logic [2:0]  dbg_sel,
   input  logic [31:0] dbg_data,
   output logic        dbg_gnt,
`endif
   input  logic        clr_req,
   output logic        clr_busy,
   output logic        clr_done,
   output logic [2:0]  rf_sel_z,
   output logic [1:0]  rf_mem_instr,
   output logic [31:0] rf_wdata
);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t      state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic        rr_mem, rr_nxt;
   logic        any_gnt, alu_el, mem_el;
   logic        alu_gnt_nxt, mem_gnt_nxt, busy_nxt, done_nxt;
   logic [2:0]  sel_nxt;
   logic [1:0]  instr_nxt;
   logic [31:0] wdata_nxt;
`ifdef GPREG_WB_DBG_EN
   logic        dbg_el, dbg_gnt_nxt;
   assign any_gnt = alu_gnt | mem_gnt | dbg_gnt;
   assign dbg_el  = dbg_req & ~any_gnt;
`else
   assign any_gnt = alu_gnt | mem_gnt;
`endif
   // While any grant is being driven the granted requester has not yet had a
   // chance to drop req, so no new grant is issued; grants are therefore
   // always separated by at least one idle cycle.
   assign alu_el = alu_req & ~any_gnt;
   assign mem_el = mem_req & ~any_gnt;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rr_nxt      = rr_mem;
      alu_gnt_nxt = 1'b0;
      mem_gnt_nxt = 1'b0;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;
      sel_nxt     = rf_sel_z;
      instr_nxt   = 2'b00;
      wdata_nxt   = rf_wdata;
`ifdef GPREG_WB_DBG_EN
      dbg_gnt_nxt = 1'b0;
`endif
      if (state == CLEAR) begin
         instr_nxt = 2'b11;
         sel_nxt   = cnt;
         wdata_nxt = '0;
         busy_nxt  = 1'b1;
         cnt_nxt   = cnt + 3'd1;
         state_nxt = (cnt == 3'd7) ? IDLE : CLEAR;
      end else if (clr_busy) begin
         // register-7 write is on the port now; this edge produces the done pulse
         done_nxt = 1'b1;
      end else if (clr_req) begin
         state_nxt = CLEAR;
         cnt_nxt   = 3'd0;
      end
`ifdef GPREG_WB_DBG_EN
      else if (dbg_el) begin
         dbg_gnt_nxt = 1'b1;
         instr_nxt   = 2'b11;
         sel_nxt     = dbg_sel;
         wdata_nxt   = dbg_data;
      end
`endif
      else if (alu_el && (!mem_el || !rr_mem)) begin
         alu_gnt_nxt = 1'b1;
         instr_nxt   = 2'b11;
         sel_nxt     = alu_sel;
         wdata_nxt   = alu_data;
         rr_nxt      = 1'b1;
      end else if (mem_el) begin
         mem_gnt_nxt = 1'b1;
         instr_nxt   = 2'b11;
         sel_nxt     = mem_sel;
         wdata_nxt   = mem_data;
         rr_nxt      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= 3'd0;
         rr_mem       <= RR_INIT;
         alu_gnt      <= 1'b0;
         mem_gnt      <= 1'b0;
         clr_busy     <= 1'b0;
         clr_done     <= 1'b0;
         rf_sel_z     <= 3'd0;
         rf_mem_instr <= 2'b00;
         rf_wdata     <= '0;
`ifdef GPREG_WB_DBG_EN
         dbg_gnt      <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         rr_mem       <= rr_nxt;
         alu_gnt      <= alu_gnt_nxt;
         mem_gnt      <= mem_gnt_nxt;
         clr_busy     <= busy_nxt;
         clr_done     <= done_nxt;
         rf_sel_z     <= sel_nxt;
         rf_mem_instr <= instr_nxt;
         rf_wdata     <= wdata_nxt;
`ifdef GPREG_WB_DBG_EN
         dbg_gnt      <= dbg_gnt_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_gpreg_wb_arbiter.sv
// tb_gpreg_wb_arbiter: directed self-checking bench for gpreg_wb_arbiter (RR_INIT = 0).
module tb_gpreg_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_req = 1'b0, mem_req = 1'b0, clr_req = 1'b0;
   logic [2:0]  alu_sel = '0, mem_sel = '0;
   logic [31:0] alu_data = '0, mem_data = '0;
   logic        alu_gnt, mem_gnt, clr_busy, clr_done;
   logic [2:0]  rf_sel_z;
   logic [1:0]  rf_mem_instr;
   logic [31:0] rf_wdata;
`ifdef GPREG_WB_DBG_EN
   logic        dbg_req = 1'b0;
   logic [2:0]  dbg_sel = '0;
   logic [31:0] dbg_data = '0;
   logic        dbg_gnt;
`endif
   int n_chk = 0;
   int n_fail = 0;

   gpreg_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_req(alu_req), .alu_sel(alu_sel), .alu_data(alu_data), .alu_gnt(alu_gnt),
      .mem_req(mem_req), .mem_sel(mem_sel), .mem_data(mem_data), .mem_gnt(mem_gnt),
`ifdef GPREG_WB_DBG_EN
      .dbg_req(dbg_req), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
`endif
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
      .rf_sel_z(rf_sel_z), .rf_mem_instr(rf_mem_instr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // observed vector order: {alu_gnt, mem_gnt, clr_busy, clr_done, rf_mem_instr, rf_sel_z, rf_wdata}
   task automatic chk_out(input string tag, input logic ag, input logic mg, input logic bz,
                          input logic dn, input logic [1:0] ins, input logic [2:0] sel,
                          input logic [31:0] wd);
      chk(tag, {23'd0, alu_gnt, mem_gnt, clr_busy, clr_done, rf_mem_instr, rf_sel_z, rf_wdata},
               {23'd0, ag, mg, bz, dn, ins, sel, wd});
   endtask

   initial begin
      logic [2:0]  es;
      logic [31:0] ed;
      rst = 1'b0;
      step();
      step();
      chk_out("reset", 0, 0, 0, 0, 2'b00, 3'd0, 32'h0);
      rst = 1'b1;

      alu_req = 1'b1; alu_sel = 3'd3; alu_data = 32'hDEADBEEF;
      step();
      chk_out("alu_single_gnt", 1, 0, 0, 0, 2'b11, 3'd3, 32'hDEADBEEF);
      alu_req = 1'b0;
      step();
      chk_out("alu_single_after", 0, 0, 0, 0, 2'b00, 3'd3, 32'hDEADBEEF);

      rst = 1'b0;
      step();
      chk_out("reset_clears_port", 0, 0, 0, 0, 2'b00, 3'd0, 32'h0);
      rst = 1'b1;

      alu_req = 1'b1; alu_sel = 3'd1; alu_data = 32'hA1A1A1A1;
      mem_req = 1'b1; mem_sel = 3'd2; mem_data = 32'hB2B2B2B2;
      es = 3'd0; ed = 32'h0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i % 4 == 0) begin
            es = 3'd1; ed = 32'hA1A1A1A1;
            chk_out("rr_alu", 1, 0, 0, 0, 2'b11, es, ed);
         end else if (i % 4 == 2) begin
            es = 3'd2; ed = 32'hB2B2B2B2;
            chk_out("rr_mem", 0, 1, 0, 0, 2'b11, es, ed);
         end else
            chk_out("rr_gap", 0, 0, 0, 0, 2'b00, es, ed);
      end
      alu_req = 1'b0; mem_req = 1'b0;

      clr_req = 1'b1;
      mem_req = 1'b1; mem_sel = 3'd5; mem_data = 32'hC3C3C3C3;
      step();
      chk_out("clr_entry", 0, 0, 0, 0, 2'b00, 3'd2, 32'hB2B2B2B2);
      for (int i = 0; i < 8; i++) begin
         step();
         chk_out("clr_write", 0, 0, 1, 0, 2'b11, 3'(i), 32'h0);
         if (i == 3) clr_req = 1'b0;
      end
      step();
      chk_out("clr_done", 0, 0, 0, 1, 2'b00, 3'd7, 32'h0);
      step();
      chk_out("clr_then_mem", 0, 1, 0, 0, 2'b11, 3'd5, 32'hC3C3C3C3);
      mem_req = 1'b0;
      step();
      chk_out("post_mem", 0, 0, 0, 0, 2'b00, 3'd5, 32'hC3C3C3C3);

      clr_req = 1'b1;
      step();
      chk_out("clr2_entry", 0, 0, 0, 0, 2'b00, 3'd5, 32'hC3C3C3C3);
      clr_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out("clr2_write", 0, 0, 1, 0, 2'b11, 3'(i), 32'h0);
      end
      rst = 1'b0;
      step();
      chk_out("rst_mid_clear", 0, 0, 0, 0, 2'b00, 3'd0, 32'h0);
      rst = 1'b1;
      step();
      chk_out("no_done_1", 0, 0, 0, 0, 2'b00, 3'd0, 32'h0);
      step();
      chk_out("no_done_2", 0, 0, 0, 0, 2'b00, 3'd0, 32'h0);
      alu_req = 1'b1; alu_sel = 3'd6; alu_data = 32'h12345678;
      step();
      chk_out("alu_after_rst", 1, 0, 0, 0, 2'b11, 3'd6, 32'h12345678);
      alu_req = 1'b0;
      step();
      chk_out("alu_after_rst_idle", 0, 0, 0, 0, 2'b00, 3'd6, 32'h12345678);

`ifdef GPREG_WB_DBG_EN
      rst = 1'b0;
      step();
      rst = 1'b1;
      dbg_req = 1'b1; dbg_sel = 3'd4; dbg_data = 32'hD0D0D0D0;
      alu_req = 1'b1; alu_sel = 3'd1; alu_data = 32'hA1A1A1A1;
      mem_req = 1'b1; mem_sel = 3'd2; mem_data = 32'hB2B2B2B2;
      step();
      chk("dbg_first_gnt", {63'd0, dbg_gnt}, 64'd1);
      chk_out("dbg_first", 0, 0, 0, 0, 2'b11, 3'd4, 32'hD0D0D0D0);
      dbg_req = 1'b0;
      step();
      chk_out("dbg_gap", 0, 0, 0, 0, 2'b00, 3'd4, 32'hD0D0D0D0);
      step();
      chk("dbg_then_alu_dbg", {63'd0, dbg_gnt}, 64'd0);
      chk_out("dbg_then_alu", 1, 0, 0, 0, 2'b11, 3'd1, 32'hA1A1A1A1);
      alu_req = 1'b0;
      step();
      chk_out("dbg_gap2", 0, 0, 0, 0, 2'b00, 3'd1, 32'hA1A1A1A1);
      step();
      chk_out("dbg_then_mem", 0, 1, 0, 0, 2'b11, 3'd2, 32'hB2B2B2B2);
      mem_req = 1'b0;
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
